// File: rtl/ram_sync_param.sv
// Parametrised single-port synchronous RAM with registered read path, tri-state read bus,
// a hardware clear sweep to INIT_VAL, and a pulse flag for accesses dropped while clearing.
module ram_sync_param #(
   parameter int               DATA_W         = 4,
   parameter int               ADDR_W         = 4,
   parameter bit               CLEAR_ON_RESET = 1'b1,
   parameter logic [DATA_W-1:0] INIT_VAL      = {DATA_W{1'b0}}
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              csn,
   input  logic              rwn,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] datain,
   input  logic              clr_req,
   output logic              busy,
   output logic              dout_valid,
   output logic [DATA_W-1:0] dataout,
   output logic              drop
);

   localparam int                DEPTH     = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
   logic [DATA_W-1:0]   dout_reg_q, dout_reg_d;
   logic                dout_valid_q, dout_valid_d;
   logic                drop_q, drop_d;

   logic                mem_we_s;
   logic [ADDR_W-1:0]   mem_waddr_s;
   logic [DATA_W-1:0]   mem_wdata_s;
   logic [DATA_W-1:0]   mem [DEPTH];

   // Next-state, sweep pointer, read capture and memory write-port selection
   always_comb begin
      state_d      = state_q;
      clr_ptr_d    = clr_ptr_q;
      dout_reg_d   = dout_reg_q;
      dout_valid_d = 1'b0;
      drop_d       = 1'b0;
      mem_we_s     = 1'b0;
      mem_waddr_s  = addr;
      mem_wdata_s  = datain;
      case (state_q)
         ST_CLEAR: begin
            // The sweep owns the write port; bus accesses and clr_req are ignored
            mem_we_s    = 1'b1;
            mem_waddr_s = clr_ptr_q;
            mem_wdata_s = INIT_VAL;
            drop_d      = ~csn;
            if (clr_ptr_q == LAST_ADDR) begin
               clr_ptr_d = {ADDR_W{1'b0}};
               state_d   = ST_READY;
            end else begin
               clr_ptr_d = clr_ptr_q + ADDR_W'(1);
            end
         end
         ST_READY: begin
            if (!csn) begin
               if (rwn) begin
                  dout_reg_d   = mem[addr];
                  dout_valid_d = 1'b1;
               end else begin
                  mem_we_s = 1'b1;
               end
            end else begin
               dout_valid_d = 1'b0;
            end
            if (clr_req) begin
               state_d   = ST_CLEAR;
               clr_ptr_d = {ADDR_W{1'b0}};
            end else begin
               state_d = ST_READY;
            end
         end
         default: begin
            state_d   = ST_READY;
            clr_ptr_d = {ADDR_W{1'b0}};
         end
      endcase
   end

   // Control and read-path registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         if (CLEAR_ON_RESET) begin
            state_q <= ST_CLEAR;
         end else begin
            state_q <= ST_READY;
         end
         clr_ptr_q    <= {ADDR_W{1'b0}};
         dout_reg_q   <= {DATA_W{1'b0}};
         dout_valid_q <= 1'b0;
         drop_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         clr_ptr_q    <= clr_ptr_d;
         dout_reg_q   <= dout_reg_d;
         dout_valid_q <= dout_valid_d;
         drop_q       <= drop_d;
      end
   end

   // Storage array: deliberately not reset, initialised only by the sweep
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem[mem_waddr_s] <= mem_wdata_s;
      end
   end

   assign busy       = (state_q == ST_CLEAR);
   assign dout_valid = dout_valid_q;
   assign drop       = drop_q;
   assign dataout    = dout_valid_q ? dout_reg_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_ram_sync_param.sv
// Scoreboard bench for ram_sync_param: one instance with the clear-on-reset sweep, one without.
module tb_ram_sync_param;

   typedef struct {
      logic [7:0] data;
      int         due;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   // instance 0: DATA_W=8, ADDR_W=4, CLEAR_ON_RESET=1, INIT_VAL=A5
   logic       rst0 = 1'b1, csn0 = 1'b1, rwn0 = 1'b1, clr0 = 1'b0;
   logic [3:0] addr0 = 4'd0;
   logic [7:0] din0 = 8'd0;
   wire        busy0, dv0, drop0;
   wire  [7:0] dout0;

   // instance 1: CLEAR_ON_RESET=0
   logic       rst1 = 1'b1, csn1 = 1'b1, rwn1 = 1'b1, clr1 = 1'b0;
   logic [3:0] addr1 = 4'd0;
   logic [7:0] din1 = 8'd0;
   wire        busy1, dv1, drop1;
   wire  [7:0] dout1;

   ram_sync_param #(.DATA_W(8), .ADDR_W(4), .CLEAR_ON_RESET(1'b1), .INIT_VAL(8'hA5)) dut0 (
      .clk(clk), .rst(rst0), .csn(csn0), .rwn(rwn0), .addr(addr0), .datain(din0),
      .clr_req(clr0), .busy(busy0), .dout_valid(dv0), .dataout(dout0), .drop(drop0));

   ram_sync_param #(.DATA_W(8), .ADDR_W(4), .CLEAR_ON_RESET(1'b0), .INIT_VAL(8'h00)) dut1 (
      .clk(clk), .rst(rst1), .csn(csn1), .rwn(rwn1), .addr(addr1), .datain(din1),
      .clr_req(clr1), .busy(busy1), .dout_valid(dv1), .dataout(dout1), .drop(drop1));

   exp_t q0[$];
   exp_t q1[$];
   exp_t e0, e1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // monitor for instance 0: every valid cycle must match the next scheduled read
   always @(negedge clk) begin
      if (q0.size() > 0 && q0[0].due <= cyc) begin
         e0 = q0.pop_front();
         checks++;
         if (dv0 !== 1'b1 || dout0 !== e0.data || e0.due != cyc) begin
            errors++;
            $display("FAIL rd0: valid %b data %h cycle %0d expected valid 1 data %h cycle %0d",
                     dv0, dout0, cyc, e0.data, e0.due);
         end
      end else if (dv0 === 1'b1) begin
         checks++;
         errors++;
         $display("FAIL rd0_unexpected: dout_valid 1 data %h expected dout_valid 0 (cycle %0d)", dout0, cyc);
      end
   end

   // monitor for instance 1
   always @(negedge clk) begin
      if (q1.size() > 0 && q1[0].due <= cyc) begin
         e1 = q1.pop_front();
         checks++;
         if (dv1 !== 1'b1 || dout1 !== e1.data || e1.due != cyc) begin
            errors++;
            $display("FAIL rd1: valid %b data %h cycle %0d expected valid 1 data %h cycle %0d",
                     dv1, dout1, cyc, e1.data, e1.due);
         end
      end else if (dv1 === 1'b1) begin
         checks++;
         errors++;
         $display("FAIL rd1_unexpected: dout_valid 1 data %h expected dout_valid 0 (cycle %0d)", dout1, cyc);
      end
   end

   // drive one cycle of instance 0 (call right after a negedge); reads enqueue expectations
   task automatic bus0(input logic c, input logic r, input logic [3:0] a, input logic [7:0] d,
                       input logic clr, input bit expect_rd, input logic [7:0] exp_data);
      exp_t e;
      csn0 = c; rwn0 = r; addr0 = a; din0 = d; clr0 = clr;
      if (expect_rd) begin
         e.data = exp_data;
         e.due  = cyc + 1;
         q0.push_back(e);
      end
      @(negedge clk);
   endtask

   task automatic bus1(input logic c, input logic r, input logic [3:0] a, input logic [7:0] d,
                       input bit expect_rd, input logic [7:0] exp_data);
      exp_t e;
      csn1 = c; rwn1 = r; addr1 = a; din1 = d;
      if (expect_rd) begin
         e.data = exp_data;
         e.due  = cyc + 1;
         q1.push_back(e);
      end
      @(negedge clk);
   endtask

   // counts negedges with busy0 high, starting at the current one
   task automatic count_busy(output int n);
      n = 0;
      while (busy0 === 1'b1 && n < 40) begin
         n++;
         @(negedge clk);
      end
   endtask

   int n;

   initial begin
      // reset state of both instances
      @(negedge clk);
      @(negedge clk);
      check("rst_busy0", busy0, 1);
      check("rst_dv0", dv0, 0);
      check("rst_drop0", drop0, 0);
      check("rst_busy1", busy1, 0);
      check("rst_dv1", dv1, 0);

      // initial sweep: 16 busy cycles, then every location reads A5
      rst0 = 1'b0;
      count_busy(n);
      check("sweep_len", n, 16);
      for (int i = 0; i < 16; i++) bus0(1'b0, 1'b1, 4'(i), 8'h00, 1'b0, 1'b1, 8'hA5);
      bus0(1'b1, 1'b1, 4'd0, 8'h00, 1'b0, 1'b0, 8'h00);
      check("idle_dv", dv0, 0);

      // write then read-after-write
      bus0(1'b0, 1'b0, 4'd5, 8'h3C, 1'b0, 1'b0, 8'h00);
      check("wr_resp_dv", dv0, 0);
      bus0(1'b0, 1'b1, 4'd5, 8'h00, 1'b0, 1'b1, 8'h3C);
      bus0(1'b1, 1'b1, 4'd0, 8'h00, 1'b0, 1'b0, 8'h00);

      // back-to-back reads
      bus0(1'b0, 1'b0, 4'd1, 8'h11, 1'b0, 1'b0, 8'h00);
      bus0(1'b0, 1'b0, 4'd2, 8'h22, 1'b0, 1'b0, 8'h00);
      bus0(1'b0, 1'b0, 4'd3, 8'h33, 1'b0, 1'b0, 8'h00);
      bus0(1'b0, 1'b1, 4'd1, 8'h00, 1'b0, 1'b1, 8'h11);
      bus0(1'b0, 1'b1, 4'd2, 8'h00, 1'b0, 1'b1, 8'h22);
      bus0(1'b0, 1'b1, 4'd3, 8'h00, 1'b0, 1'b1, 8'h33);
      bus0(1'b1, 1'b1, 4'd0, 8'h00, 1'b0, 1'b0, 8'h00);
      check("b2b_dv_off", dv0, 0);

      // clr_req with a write; drop on access during busy; clr_req during busy ignored
      bus0(1'b0, 1'b0, 4'd2, 8'hFF, 1'b1, 1'b0, 8'h00);
      n = 0;
      while (busy0 === 1'b1 && n < 40) begin
         n++;
         if (n == 1) begin
            csn0 = 1'b0; rwn0 = 1'b1; addr0 = 4'd2; clr0 = 1'b0;
         end else if (n == 2) begin
            check("drop_hi", drop0, 1);
            check("drop_dv", dv0, 0);
            csn0 = 1'b1;
         end else if (n == 3) begin
            check("drop_lo", drop0, 0);
         end else if (n == 4) begin
            clr0 = 1'b1;
         end else begin
            clr0 = 1'b0;
         end
         @(negedge clk);
      end
      check("clr_len", n, 16);
      bus0(1'b0, 1'b1, 4'd2, 8'h00, 1'b0, 1'b1, 8'hA5);
      bus0(1'b0, 1'b1, 4'd1, 8'h00, 1'b0, 1'b1, 8'hA5);

      // read accompanying clr_req still completes; then reset mid-sweep restarts it
      bus0(1'b0, 1'b0, 4'd9, 8'h77, 1'b0, 1'b0, 8'h00);
      bus0(1'b0, 1'b1, 4'd9, 8'h00, 1'b1, 1'b1, 8'h77);
      csn0 = 1'b1; clr0 = 1'b0;
      for (int i = 0; i < 6; i++) @(negedge clk);
      check("pre_rst_busy", busy0, 1);
      rst0 = 1'b1;
      @(negedge clk);
      check("in_rst_busy", busy0, 1);
      rst0 = 1'b0;
      count_busy(n);
      check("rst_sweep_len", n, 16);
      for (int i = 0; i < 16; i++) bus0(1'b0, 1'b1, 4'(15 - i), 8'h00, 1'b0, 1'b1, 8'hA5);
      bus0(1'b1, 1'b1, 4'd0, 8'h00, 1'b0, 1'b0, 8'h00);

      // instance without clear on reset
      rst1 = 1'b0;
      @(negedge clk);
      check("nocl_busy", busy1, 0);
      bus1(1'b0, 1'b0, 4'd15, 8'h5A, 1'b0, 8'h00);
      bus1(1'b0, 1'b1, 4'd15, 8'h00, 1'b1, 8'h5A);
      bus1(1'b0, 1'b0, 4'd0, 8'hC3, 1'b0, 8'h00);
      bus1(1'b0, 1'b1, 4'd0, 8'h00, 1'b1, 8'hC3);
      bus1(1'b1, 1'b1, 4'd0, 8'h00, 1'b0, 8'h00);
      check("nocl_busy_end", busy1, 0);
      check("nocl_drop", drop1, 0);

      for (int i = 0; i < 3; i++) @(negedge clk);
      check("q0_drained", q0.size(), 0);
      check("q1_drained", q1.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
